// File: rtl/snake_input_ctrl.sv
// snake_input_ctrl: debounced direction buttons -> 2-deep legal-turn queue committed on game ticks (clk/rst, btn_* raw pins, run, game_en tick, dir, q_level, drop)
module snake_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TICK_DIV = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       run,
    output logic       game_en,
    output logic [1:0] dir,
    output logic [1:0] q_level,
    output logic       drop
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = $clog2(TICK_DIV);
    logic [3:0] w_btn, r_s1, r_s2, r_stb, w_done, w_press;
    logic [CW-1:0] r_cnt [4];
    logic [TW-1:0] r_tcnt;
    logic r_ge, r_drop;
    logic [1:0] r_dir, r_q0, r_q1, r_lvl, w_p, w_ref, w_lvl_p;
    logic w_tick, w_pop, w_legal, w_push;
    assign w_btn = {btn_right, btn_left, btn_down, btn_up};
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_done[k] = (r_s2[k] != r_stb[k]) && (r_cnt[k] == CW'(DEBOUNCE_CYCLES - 1));
            w_press[k] = w_done[k] & r_s2[k];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_stb <= '0;
            for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
        end else begin
            r_s1 <= w_btn;
            r_s2 <= r_s1;
            for (int k = 0; k < 4; k++) begin
                r_cnt[k] <= (r_s2[k] == r_stb[k] || w_done[k]) ? '0 : r_cnt[k] + 1'b1;
                r_stb[k] <= w_done[k] ? r_s2[k] : r_stb[k];
            end
        end
    end
    always_comb begin
        w_p = w_press[0] ? 2'b00 : w_press[1] ? 2'b11 : w_press[2] ? 2'b01 : 2'b10;
        w_ref = (r_lvl == 2'd0) ? r_dir : (r_lvl == 2'd1) ? r_q0 : r_q1;
        w_tick = run && (r_tcnt == TW'(TICK_DIV - 1));
        w_pop = w_tick && (r_lvl != 2'd0);
        w_legal = (|w_press) && (w_p != w_ref) && ((w_p ^ w_ref) != 2'b11);
        w_push = w_legal && (r_lvl != 2'd2 || w_pop);
        w_lvl_p = r_lvl - {1'b0, w_pop};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
            r_ge <= 1'b0;
            r_drop <= 1'b0;
            r_dir <= 2'b10;
            r_q0 <= 2'b00;
            r_q1 <= 2'b00;
            r_lvl <= 2'd0;
        end else begin
            r_tcnt <= run ? (w_tick ? '0 : r_tcnt + 1'b1) : r_tcnt;
            r_ge <= w_tick;
            r_drop <= w_legal && !w_push;
            r_dir <= w_pop ? r_q0 : r_dir;
            r_q0 <= (w_push && w_lvl_p == 2'd0) ? w_p : (w_pop ? r_q1 : r_q0);
            r_q1 <= (w_push && w_lvl_p == 2'd1) ? w_p : r_q1;
            r_lvl <= w_lvl_p + {1'b0, w_push};
        end
    end
    assign game_en = r_ge;
    assign dir = r_dir;
    assign q_level = r_lvl;
    assign drop = r_drop;
endmodule

// File: tb/tb_snake_input_ctrl.sv
// tb_snake_input_ctrl: randomized and directed stimulus against a press-schedule and FIFO reference model
module tb_snake_input_ctrl;
    localparam int DB = 4;
    localparam int TD = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bu = 1'b0, bd = 1'b0, bl = 1'b0, br = 1'b0;
    logic run = 1'b0;
    logic game_en, drop;
    logic [1:0] dir, q_level;
    int nvec = 0;
    int nerr = 0;
    int edge_n = 0;
    int free_at [4];
    bit [3:0] pin_plan [int];
    bit [3:0] press_plan [int];
    bit [1:0] mq [$];
    bit [1:0] m_dir = 2'b10;
    bit m_ge = 1'b0, m_drop = 1'b0;
    int run_cnt = 0;

    snake_input_ctrl #(.DEBOUNCE_CYCLES(DB), .TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .btn_up(bu), .btn_down(bd), .btn_left(bl), .btn_right(br),
        .run(run), .game_en(game_en), .dir(dir), .q_level(q_level), .drop(drop)
    );

    always #5 clk = ~clk;

    // Mask bits: 0 up, 1 down, 2 left, 3 right. Pin is high for the edges start..start+len-1;
    // a pulse of at least DB samples becomes a press DB+1 edges after its first sample.
    function automatic void add_pulse(bit [3:0] mask, int start, int len);
        for (int e = start; e < start + len; e++)
            pin_plan[e] = (pin_plan.exists(e) ? pin_plan[e] : 4'b0) | mask;
        if (len >= DB)
            press_plan[start + DB + 1] = (press_plan.exists(start + DB + 1) ? press_plan[start + DB + 1] : 4'b0) | mask;
        for (int b = 0; b < 4; b++)
            if (mask[b]) free_at[b] = start + len + 5;
    endfunction

    function automatic void model_edge();
        bit [3:0] m;
        bit [1:0] p, r;
        bit tick;
        if (rst) begin
            mq.delete();
            press_plan.delete();
            m_dir = 2'b10;
            run_cnt = 0;
            m_ge = 1'b0;
            m_drop = 1'b0;
            return;
        end
        tick = run && ((run_cnt + 1) % TD == 0);
        if (run) run_cnt++;
        m = press_plan.exists(edge_n) ? press_plan[edge_n] : 4'b0;
        p = m[0] ? 2'b00 : m[1] ? 2'b11 : m[2] ? 2'b01 : 2'b10;
        r = (mq.size() > 0) ? mq[$] : m_dir;
        m_ge = tick;
        m_drop = 1'b0;
        if (tick && mq.size() > 0) m_dir = mq.pop_front();
        if (m != 4'b0 && p != r && (p ^ r) != 2'b11) begin
            if (mq.size() < 2) mq.push_back(p);
            else m_drop = 1'b1;
        end
    endfunction

    function automatic logic [5:0] exp_vec();
        return {m_ge, m_dir, 2'(mq.size()), m_drop};
    endfunction

    task automatic step();
        bit [3:0] pv;
        pv = pin_plan.exists(edge_n + 1) ? pin_plan[edge_n + 1] : 4'b0;
        {br, bl, bd, bu} = pv;
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run = 1'b0;
        repeat (3) begin
            step();
            nvec++;
            if ({game_en, dir, q_level, drop} !== 6'b0_10_00_0) begin
                nerr++;
                $display("FAIL reset_hold e=%0d got=%b exp=%b", edge_n, {game_en, dir, q_level, drop}, 6'b0_10_00_0);
            end
        end
        rst = 1'b0;
        run = 1'b1;
        for (int k = 1; k <= 3 * TD; k++) begin
            step();
            nvec++;
            if (game_en !== 1'(k % TD == 0) || dir !== 2'b10) begin
                nerr++;
                $display("FAIL reset_tick k=%0d got ge=%b dir=%b exp ge=%b dir=10", k, game_en, dir, 1'(k % TD == 0));
            end
        end
    endtask

    task automatic test_debounce();
        int s;
        do_reset();
        run = 1'b1;
        add_pulse(4'b0001, edge_n + 1, 3);
        repeat (12) begin
            step();
            nvec++;
            if ({game_en, dir, q_level, drop} !== exp_vec() || q_level !== 2'd0) begin
                nerr++;
                $display("FAIL debounce_glitch e=%0d got=%b exp=%b", edge_n, {game_en, dir, q_level, drop}, exp_vec());
            end
        end
        s = edge_n + 1;
        add_pulse(4'b0001, s, 10);
        repeat (24) begin
            step();
            nvec++;
            if ({game_en, dir, q_level, drop} !== exp_vec()) begin
                nerr++;
                $display("FAIL debounce_hold e=%0d got=%b exp=%b", edge_n, {game_en, dir, q_level, drop}, exp_vec());
            end
            if (edge_n == s + 4 || edge_n == s + 5) begin
                nvec++;
                if (q_level !== 2'(edge_n - s - 4)) begin
                    nerr++;
                    $display("FAIL debounce_latency e=%0d got q=%0d exp q=%0d", edge_n, q_level, edge_n - s - 4);
                end
            end
        end
        repeat (10) step();
    endtask

    task automatic test_reversal();
        int drops = 0;
        int busy = 0;
        do_reset();
        run = 1'b1;
        add_pulse(4'b0100, edge_n + 1, 5);
        add_pulse(4'b1000, edge_n + 11, 5);
        repeat (25) begin
            step();
            drops += int'(drop);
            busy += int'(q_level != 2'd0);
            nvec++;
            if ({game_en, dir, q_level, drop} !== exp_vec()) begin
                nerr++;
                $display("FAIL reversal e=%0d got=%b exp=%b", edge_n, {game_en, dir, q_level, drop}, exp_vec());
            end
        end
        nvec++;
        if (drops != 0 || busy != 0 || dir !== 2'b10) begin
            nerr++;
            $display("FAIL reversal_reject got drops=%0d busy=%0d dir=%b exp 0 0 10", drops, busy, dir);
        end
    endtask

    task automatic test_queue();
        int s;
        int drops = 0;
        do_reset();
        run = 1'b1;
        s = edge_n + 1;
        add_pulse(4'b0001, s, 5);
        add_pulse(4'b0100, s + 1, 5);
        repeat (24) begin
            step();
            nvec++;
            if ({game_en, dir, q_level, drop} !== exp_vec()) begin
                nerr++;
                $display("FAIL queue_two e=%0d got=%b exp=%b", edge_n, {game_en, dir, q_level, drop}, exp_vec());
            end
            if (edge_n == s + 6) begin
                nvec++;
                if (q_level !== 2'd2) begin
                    nerr++;
                    $display("FAIL queue_full got q=%0d exp q=2", q_level);
                end
            end
        end
        run = 1'b0;
        s = edge_n + 1;
        add_pulse(4'b0001, s, 5);
        add_pulse(4'b0100, s + 1, 5);
        add_pulse(4'b0010, s + 2, 5);
        repeat (14) begin
            step();
            drops += int'(drop);
            nvec++;
            if ({game_en, dir, q_level, drop} !== exp_vec()) begin
                nerr++;
                $display("FAIL queue_drop e=%0d got=%b exp=%b", edge_n, {game_en, dir, q_level, drop}, exp_vec());
            end
        end
        nvec++;
        if (drops != 1) begin
            nerr++;
            $display("FAIL queue_drop_count got=%0d exp=1", drops);
        end
        run = 1'b1;
        repeat (24) begin
            step();
            nvec++;
            if ({game_en, dir, q_level, drop} !== exp_vec()) begin
                nerr++;
                $display("FAIL queue_drain e=%0d got=%b exp=%b", edge_n, {game_en, dir, q_level, drop}, exp_vec());
            end
        end
    endtask

    task automatic test_simul_pushpop();
        int s, k, t;
        do_reset();
        run = 1'b1;
        s = edge_n + 1;
        add_pulse(4'b0101, s, 5);
        repeat (14) begin
            step();
            nvec++;
            if ({game_en, dir, q_level, drop} !== exp_vec()) begin
                nerr++;
                $display("FAIL simul_press e=%0d got=%b exp=%b", edge_n, {game_en, dir, q_level, drop}, exp_vec());
            end
        end
        nvec++;
        if (dir !== 2'b00) begin
            nerr++;
            $display("FAIL simul_priority got dir=%b exp dir=00", dir);
        end
        k = TD - (run_cnt % TD);
        while (k < 12) k += TD;
        t = edge_n + k;
        add_pulse(4'b0100, t - 11, 5);
        add_pulse(4'b0010, t - 10, 5);
        add_pulse(4'b1000, t - 5, 5);
        while (edge_n < t + 10) begin
            step();
            nvec++;
            if ({game_en, dir, q_level, drop} !== exp_vec()) begin
                nerr++;
                $display("FAIL pushpop e=%0d got=%b exp=%b", edge_n, {game_en, dir, q_level, drop}, exp_vec());
            end
            if (edge_n == t) begin
                nvec++;
                if ({game_en, q_level, drop} !== 4'b1_10_0) begin
                    nerr++;
                    $display("FAIL pushpop_tick got ge,q,drop=%b exp=1100", {game_en, q_level, drop});
                end
            end
        end
        repeat (20) step();
    endtask

    task automatic test_pause_reset();
        do_reset();
        run = 1'b1;
        repeat (3) step();
        run = 1'b0;
        add_pulse(4'b0001, edge_n + 1, 5);
        repeat (20) begin
            step();
            nvec++;
            if ({game_en, dir, q_level, drop} !== exp_vec() || game_en !== 1'b0) begin
                nerr++;
                $display("FAIL pause e=%0d got=%b exp=%b", edge_n, {game_en, dir, q_level, drop}, exp_vec());
            end
        end
        nvec++;
        if (q_level !== 2'd1) begin
            nerr++;
            $display("FAIL pause_queued got q=%0d exp q=1", q_level);
        end
        run = 1'b1;
        repeat (12) begin
            step();
            nvec++;
            if ({game_en, dir, q_level, drop} !== exp_vec()) begin
                nerr++;
                $display("FAIL resume e=%0d got=%b exp=%b", edge_n, {game_en, dir, q_level, drop}, exp_vec());
            end
        end
        nvec++;
        if (dir !== 2'b00) begin
            nerr++;
            $display("FAIL resume_commit got dir=%b exp dir=00", dir);
        end
        run = 1'b0;
        add_pulse(4'b0100, edge_n + 1, 5);
        add_pulse(4'b0010, edge_n + 2, 5);
        repeat (8) step();
        nvec++;
        if (q_level !== 2'd2) begin
            nerr++;
            $display("FAIL prereset_full got q=%0d exp q=2", q_level);
        end
        add_pulse(4'b1000, edge_n + 1, 4);
        repeat (2) step();
        rst = 1'b1;
        step();
        nvec++;
        if ({q_level, dir} !== 4'b00_10) begin
            nerr++;
            $display("FAIL midreset got q,dir=%b exp=0010", {q_level, dir});
        end
        rst = 1'b0;
        repeat (12) begin
            step();
            nvec++;
            if ({game_en, dir, q_level, drop} !== exp_vec()) begin
                nerr++;
                $display("FAIL postreset e=%0d got=%b exp=%b", edge_n, {game_en, dir, q_level, drop}, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int b;
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 4; i++) free_at[i] = edge_n;
        repeat (800) begin
            if ($urandom_range(0, 2) == 0) begin
                b = $urandom_range(0, 3);
                if (free_at[b] <= edge_n + 1) add_pulse(4'(1 << b), edge_n + 1, $urandom_range(1, 8));
            end
            if ($urandom_range(0, 40) == 0) run = ~run;
            step();
            nvec++;
            if ({game_en, dir, q_level, drop} !== exp_vec()) begin
                nerr++;
                $display("FAIL random e=%0d got=%b exp=%b", edge_n, {game_en, dir, q_level, drop}, exp_vec());
            end
        end
        run = 1'b1;
        repeat (30) begin
            step();
            nvec++;
            if ({game_en, dir, q_level, drop} !== exp_vec()) begin
                nerr++;
                $display("FAIL random_drain e=%0d got=%b exp=%b", edge_n, {game_en, dir, q_level, drop}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_reversal();
        test_queue();
        test_simul_pushpop();
        test_pause_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
